size_field_patcher: RTL
=======================

Name: size_field_patcher

Overview:
- Sits directly downstream of the encoder sequencer and consumes its per-cycle size write-back requests (offset_addr, val, byte_size).
- Buffers the requests and serialises each one into big-endian byte writes on the output bitstream memory's byte-wide write port.
- This back-fills the slice, picture, frame, Y and Cb size fields after encoding.
- One memory byte write per cycle. Requests may arrive back-to-back on consecutive cycles.

Parameters:
- FIFO_DEPTH, 4, number of pending requests buffered (power of two, >=2).
- ADDR_WIDTH, 32, width of the memory byte address.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low
- offset_addr  input  32  byte address of the field's MSB
- val  input  32  value to store, right-aligned
- byte_size  input  32  field width in bytes. 0 means no request this cycle; a nonzero value is a one-cycle request.
- mem_wr_en  output  1  byte write strobe
- mem_addr  output  ADDR_WIDTH  byte write address
- mem_wr_data  output  8  byte write data
- busy  output  1  FIFO non-empty or a write is in progress
- overflow  output  1  sticky: a request was dropped because the FIFO was full
- bad_size  output  1  sticky: a request with byte_size > 4 was dropped
- patch_count  output  16  number of requests fully written, saturating

Behaviour:
- Reset: all outputs are 0, the FIFO is empty and the FSM is in IDLE. Reset assertion mid-request aborts it immediately; no further bytes are written. Stickies clear only on reset.
- Request sampling:
  - Sampled every rising edge when byte_size != 0.
  - byte_size 1..4: push {offset_addr[ADDR_WIDTH-1:0], val, byte_size[2:0]}.
  - byte_size > 4: not pushed; set bad_size.
- Push when full:
  - A pop in the same cycle frees a slot and the push succeeds.
  - Otherwise the request is dropped and overflow is set.
- FSM:
  - IDLE: if the FIFO is non-empty, pop into working registers (addr, val, remaining = byte_size) and go to WRITE.
  - WRITE: each cycle, register mem_wr_en=1, mem_addr = base + i, mem_wr_data = val byte (byte_size-1-i), for i = 0..byte_size-1. This is big-endian: the MSB goes to the lowest address.
  - On the last byte, increment patch_count (saturate at 0xFFFF). Then either pop the next entry in the same cycle and stay in WRITE (zero-bubble), or go to IDLE if the FIFO is empty.
- Latency: a request sampled at edge E0 into an idle, empty block produces its first mem_wr_en=1 in the cycle after edge E2. That is 2 cycles: push at E0, pop/load at E1, first byte registered at E2. Consecutive bytes and consecutive requests have no gaps.
- Timing of mem_wr_* outputs: all are registered. mem_wr_en=0 drives mem_addr and mem_wr_data to 0.
- Address arithmetic: computed modulo 2^ADDR_WIDTH, so wrap-around is allowed and not flagged.
- val bits above the field width are ignored.
- busy = FIFO not empty OR FSM != IDLE OR mem_wr_en.
- Throughput: the sequencer's worst case is 5 requests of 2+4+4+2+2 = 14 bytes on 5 consecutive cycles. With FIFO_DEPTH=4 this completes without overflow.

Decomposition:
- Shared encoder package holds:
  - request struct {addr, val, size[2:0]}
  - constant MAX_FIELD_BYTES = 4
  - FSM state enum {IDLE, WRITE}
- Sub-module patch_req_fifo: synchronous FIFO with push/pop/full/empty, simultaneous push+pop when full allowed, async active-low reset.
- The FSM and byte serialiser stay in the top module.

Test Plan:
- offset_addr=0x10, val=0x1234, byte_size=2 -> 2 cycles later writes (0x10, 0x12), (0x11, 0x34); patch_count=1; busy then drops.
- offset_addr=0x20, val=0xAABBCCDD, byte_size=4 -> writes 0x20:AA, 0x21:BB, 0x22:CC, 0x23:DD on consecutive cycles.
- 5 back-to-back requests of sizes 2,4,4,2,2 at addresses 0x08,0x14,0x18,0x30,0x32 -> 14 contiguous write cycles in order, overflow=0, patch_count=5.
- FIFO_DEPTH=2 with 5 back-to-back 4-byte requests -> overflow=1; only the accepted requests (first 3: one loaded, two queued) are written; patch_count=3.
- byte_size=5 at 0x40 -> no writes, bad_size=1. A following valid 1-byte request (0x41, val 0x7F) writes 0x41:7F.
- reset_n low after the 2nd byte of a 4-byte request -> mem_wr_en=0 immediately, no further writes after release, all outputs 0, patch_count=0.

Source files
------------

// File: rtl/size_field_patcher_pkg.sv
// -----------------------------------------------------------------------------
// size_field_patcher_pkg
// Types and constants shared by the size-field patcher and its request FIFO.
//   patch_req_t     : one buffered size write-back request {addr, val, size}
//   patch_state_t   : serialiser FSM states
//   MAX_FIELD_BYTES : widest size field the encoder ever back-fills
//   field_byte()    : selects byte idx (0 = LSB) of a right-aligned value
// -----------------------------------------------------------------------------
package size_field_patcher_pkg;

    localparam int MAX_FIELD_BYTES = 4;

    typedef struct packed {
        logic [31:0] addr;   // byte address of the field's MSB
        logic [31:0] val;    // right-aligned field value
        logic [2:0]  size;   // field width in bytes, 1..MAX_FIELD_BYTES
    } patch_req_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } patch_state_t;

    function automatic logic [7:0] field_byte(input logic [31:0] v, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = v[7:0];
            3'd1:    b = v[15:8];
            3'd2:    b = v[23:16];
            3'd3:    b = v[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/size_field_patcher_fifo.sv
// -----------------------------------------------------------------------------
// patch_req_fifo
// Synchronous request FIFO with show-ahead read data. A push while full is
// accepted only when a pop happens in the same cycle; otherwise it is ignored
// (the parent flags the drop).
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push, push_data: write request and its payload
//   pop            : consume the head entry (ignored when empty)
//   pop_data       : current head entry, valid while !empty
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module patch_req_fifo
    import size_field_patcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  patch_req_t push_data,
    input  logic       pop,
    output patch_req_t pop_data,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    patch_req_t     storage [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = storage[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and a resettable array costs flops.
    always_ff @(posedge clock) begin
        if (do_push) storage[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/size_field_patcher.sv
// -----------------------------------------------------------------------------
// size_field_patcher
// Buffers size write-back requests from the encoder sequencer and serialises
// each into big-endian byte writes (MSB at the lowest address) on the
// bitstream memory's byte write port, one byte per cycle, with no bubbles
// between consecutive requests.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   offset_addr    : byte address of the field's MSB
//   val            : right-aligned field value
//   byte_size      : field width in bytes; 0 = no request, >4 = rejected
//   mem_wr_en      : registered byte write strobe
//   mem_addr       : registered byte address (0 when not writing)
//   mem_wr_data    : registered byte data (0 when not writing)
//   busy           : work pending or in flight
//   overflow       : sticky, a request was dropped on a full FIFO
//   bad_size       : sticky, a request with byte_size > 4 was dropped
//   patch_count    : completed requests, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module size_field_patcher
    import size_field_patcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           offset_addr,
    input  logic [31:0]           val,
    input  logic [31:0]           byte_size,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wr_data,
    output logic                  busy,
    output logic                  overflow,
    output logic                  bad_size,
    output logic [15:0]           patch_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    patch_state_t          state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_val;
    logic [2:0]            remaining;

    logic       req_valid;
    logic       req_bad;
    patch_req_t push_req;
    patch_req_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       last_byte;
    logic       drop_full;

    assign req_valid = (byte_size != 32'd0) && (byte_size <= 32'(MAX_FIELD_BYTES));
    assign req_bad   = (byte_size > 32'(MAX_FIELD_BYTES));
    assign push_req  = '{addr: offset_addr, val: val, size: byte_size[2:0]};

    assign last_byte = (state == WRITE) && (remaining == 3'd1);
    // The next entry is taken either from idle or on the last byte of the
    // current one, which is what makes back-to-back requests gap-free.
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || last_byte);
    assign drop_full = req_valid && fifo_full && !fifo_pop;

    assign busy = !fifo_empty || (state != IDLE) || mem_wr_en;

    patch_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (req_valid),
        .push_data(push_req),
        .pop      (fifo_pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            cur_val     <= '0;
            remaining   <= '0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            overflow    <= 1'b0;
            bad_size    <= 1'b0;
            patch_count <= '0;
        end else begin
            if (drop_full) overflow <= 1'b1;
            if (req_bad)   bad_size <= 1'b1;

            // Write port idles at all-zero unless a byte is emitted below.
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;

            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        cur_addr  <= head.addr[ADDR_WIDTH-1:0];
                        cur_val   <= head.val;
                        remaining <= head.size;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    mem_wr_en   <= 1'b1;
                    mem_addr    <= cur_addr;
                    mem_wr_data <= field_byte(cur_val, remaining - 3'd1);
                    cur_addr    <= cur_addr + ADDR_ONE;
                    remaining   <= remaining - 3'd1;
                    if (remaining == 3'd1) begin
                        if (patch_count != 16'hFFFF) patch_count <= patch_count + 16'd1;
                        if (fifo_pop) begin
                            // NOTE: these non-blocking loads come after the
                            // per-byte updates above, so they take precedence.
                            cur_addr  <= head.addr[ADDR_WIDTH-1:0];
                            cur_val   <= head.val;
                            remaining <= head.size;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
